// File: rtl/rx_bit_timer_pkg.sv
// usb_rx_pkg: shared timing constants and types for the USB full-speed receive path
package usb_rx_pkg;
   localparam int RX_OSR = 8;
   localparam int RX_SAMPLE_PT = 3;
   localparam int RX_BITS_PER_BYTE = 8;
   localparam int PHASE_W = $clog2(RX_OSR);
   typedef logic [2:0] bit_idx_t;
endpackage

// File: rtl/rx_bit_timer_if.sv
// rx_bit_timer_if: edge/receive controls in, sample strobe and byte status out
interface rx_bit_timer_if;
   import usb_rx_pkg::*;
   logic rcving;
   logic d_edge;
   logic shift_enable;
   logic byte_received;
   bit_idx_t bit_cnt;
   modport master(output rcving, d_edge, input shift_enable, byte_received, bit_cnt);
   modport slave(input rcving, d_edge, output shift_enable, byte_received, bit_cnt);
endinterface

// File: rtl/rx_bit_timer_rollover_counter.sv
// rollover_counter: counter with clear > load > count priority, wrapping explicitly at ROLL
module rollover_counter #(
   parameter int W = 3,
   parameter int ROLL = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         count_enable,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] count
);
   logic [W-1:0] nxt;
   always_comb nxt = clear ? '0 : load ? load_val : !count_enable ? count : (count == W'(ROLL)) ? '0 : count + 1'b1;
   always_ff @(posedge clk or posedge rst)
      if (rst) count <= '0;
      else count <= nxt;
endmodule

// File: rtl/rx_bit_timer.sv
// rx_bit_timer: oversampling phase tracker that strobes mid-bit and flags completed bytes
module rx_bit_timer
   import usb_rx_pkg::*;
#(
   parameter int OSR = RX_OSR,
   parameter int SAMPLE_PT = RX_SAMPLE_PT,
   parameter int BITS_PER_BYTE = RX_BITS_PER_BYTE
) (
   input logic clk,
   input logic rst,
   rx_bit_timer_if.slave bus
);
   localparam int PW = $clog2(OSR);
   localparam int BW = $bits(bit_idx_t);
   logic [PW-1:0] phase_cnt;
   bit_idx_t bit_cnt;
   logic shift_enable;
   logic byte_received;
   // an edge marks phase 0 of a new bit, so the following cycle is already phase 1
   rollover_counter #(.W(PW), .ROLL(OSR-1)) u_phase (
      .clk(clk), .rst(rst), .clear(!bus.rcving), .count_enable(1'b1),
      .load(bus.d_edge), .load_val(PW'(1)), .count(phase_cnt)
   );
   rollover_counter #(.W(BW), .ROLL(BITS_PER_BYTE-1)) u_bits (
      .clk(clk), .rst(rst), .clear(!bus.rcving), .count_enable(shift_enable),
      .load(1'b0), .load_val('0), .count(bit_cnt)
   );
   assign shift_enable = bus.rcving && (phase_cnt == PW'(SAMPLE_PT));
   always_ff @(posedge clk or posedge rst)
      if (rst) byte_received <= 1'b0;
      else byte_received <= shift_enable && (bit_cnt == BW'(BITS_PER_BYTE-1));
   assign bus.shift_enable = shift_enable;
   assign bus.byte_received = byte_received;
   assign bus.bit_cnt = bit_cnt;
endmodule

// File: tb/tb_rx_bit_timer.sv
// tb_rx_bit_timer: randomized and directed stimulus against a time-anchored reference with a scoreboard
module tb_rx_bit_timer;
   import usb_rx_pkg::*;
   typedef struct {int t; bit se; bit br; int bc;} ev_t;
   logic clk = 0;
   logic rst = 1;
   rx_bit_timer_if bus();
   rx_bit_timer dut(.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   int tests, fails, cyc, anchor, nbits, m_ph, m_bc;
   bit pr, pe, pend, mon;
   ev_t ev_q[$];
   int bc_q[$];
   task automatic chk(input string n, input int a, input int e);
      tests++;
      if (a != e) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", n, a, e, cyc);
      end
   endtask
   // phase is time elapsed since the last alignment point (rcving rise or edge), modulo OSR
   task automatic model(input bit r, input bit e, input bit rs);
      bit se;
      ev_t ev;
      if (rs) begin
         pr = 0; pe = 0; nbits = 0; pend = 0; m_ph = 0; m_bc = 0;
         bc_q.push_back(0);
         return;
      end
      if (!pr) begin anchor = cyc; nbits = 0; end
      else if (pe) anchor = cyc - 1;
      m_ph = (cyc - anchor) % RX_OSR;
      m_bc = nbits % RX_BITS_PER_BYTE;
      se = r && (m_ph == RX_SAMPLE_PT);
      bc_q.push_back(m_bc);
      if (se || pend) begin
         ev.t = cyc; ev.se = se; ev.br = pend; ev.bc = m_bc;
         ev_q.push_back(ev);
      end
      pend = se && (m_bc == RX_BITS_PER_BYTE - 1);
      if (se) nbits++;
      pr = r; pe = e;
   endtask
   task automatic step(input bit r, input bit e, input bit rs);
      @(posedge clk); #1;
      cyc++; rst = rs; bus.rcving = r; bus.d_edge = e; mon = 1;
      model(r, e, rs);
   endtask
   always @(negedge clk) if (mon) begin
      ev_t ev;
      if (bc_q.size() == 0) chk("bc_queue_underflow", 1, 0);
      else chk("bit_cnt", int'(bus.bit_cnt), bc_q.pop_front());
      if (bus.shift_enable || bus.byte_received) begin
         if (ev_q.size() == 0) chk("unexpected_strobe_cycle", cyc, -1);
         else begin
            ev = ev_q.pop_front();
            chk("ev_cycle", cyc, ev.t);
            chk("ev_shift_enable", int'(bus.shift_enable), int'(ev.se));
            chk("ev_byte_received", int'(bus.byte_received), int'(ev.br));
         end
      end
      while (ev_q.size() != 0 && ev_q[0].t <= cyc) begin
         ev = ev_q.pop_front();
         chk("missed_strobe_cycle", -1, ev.t);
      end
   end
   initial begin
      int b;
      bus.rcving = 1; bus.d_edge = 0;
      step(1, 1, 1);
      step(1, 0, 1);
      #1 chk("rst_se", int'(bus.shift_enable), 0);
      step(0, 0, 0);
      step(0, 1, 0);
      #1 chk("rel_br", int'(bus.byte_received), 0);
      for (int rel = 0; rel < 128; rel++) begin
         step(1, 0, 0);
         #1 chk("free_se", int'(bus.shift_enable), int'(rel % 8 == 3));
         chk("free_br", int'(bus.byte_received), int'(rel == 60 || rel == 124));
      end
      for (int i = 0; i < 16 && m_ph != 5; i++) step(1, 0, 0);
      step(1, 1, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      #1 chk("resync_se", int'(bus.shift_enable), 1);
      for (int i = 0; i < 16 && m_ph != 2; i++) step(1, 0, 0);
      step(1, 1, 0);
      #1 chk("edge_sample_se", int'(bus.shift_enable), 1);
      b = int'(bus.bit_cnt);
      step(1, 0, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      #1 chk("edge_sample_se2", int'(bus.shift_enable), 1);
      chk("edge_sample_bc", int'(bus.bit_cnt), (b + 1) % 8);
      for (int i = 0; i < 100 && m_bc != 5; i++) step(1, 0, 0);
      step(0, 0, 0);
      step(1, 0, 0);
      #1 chk("abort_bc", int'(bus.bit_cnt), 0);
      step(1, 0, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      #1 chk("abort_first_se", int'(bus.shift_enable), 1);
      for (int i = 0; i < 800; i++) step($urandom_range(0, 49) != 0, $urandom_range(0, 5) == 0, 0);
      step(0, 0, 0);
      for (int i = 0; i < 200 && !(m_ph == 3 && m_bc == 4); i++) step(1, 0, 0);
      chk("async_setup_bc", int'(bus.bit_cnt), 4);
      #1 rst = 1;
      #1 chk("async_se", int'(bus.shift_enable), 0);
      chk("async_bc", int'(bus.bit_cnt), 0);
      bc_q.delete(); ev_q.delete(); bc_q.push_back(0);
      pr = 0; pe = 0; nbits = 0; pend = 0;
      step(1, 1, 1);
      for (int i = 0; i < 12; i++) step(0, i[0], 0);
      for (int i = 0; i < 20; i++) step(1, 0, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      @(posedge clk); #1 mon = 0;
      chk("leftover_events", ev_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
